uart_mmio_core: RTL and testbench

Byte-wide UART peripheral that sits behind the 0x1000_0000 / 0x1000_0004 MMIO window of the data memory.
- Serialises bytes written by the CPU onto `txd`.
- Deserialises `rxd` into a one-byte holding register that the CPU polls and reads.
- Provides the `tx_busy`, `rx_valid` and `rx_data` status that the memory map exposes.
- 8N1 framing, LSB first, fixed baud derived from parameters.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 rtl/uart_tx.sv | 146 ++++++++++++++
 rtl/uart_mmio_core.sv | 90 +++++++++
 tb/tb_uart_mmio_core.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART MMIO peripheral.
//   - FSM state encoding used by both the TX and RX engines
//   - frame constants (data width, idle line level)
//   - bit-period helper and MMIO register offsets / status bit positions
// Optional build macro: UART_PARITY_EN (even parity; only the PARITY state is
// reached when it is defined).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [3:0] MMIO_DATA_OFS    = 4'h0;
  localparam logic [3:0] MMIO_STATUS_OFS  = 4'h4;
  localparam int         STATUS_BUSY_BIT  = 1;
  localparam int         STATUS_VALID_BIT = 0;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: deserialiser with 2-FF input synchroniser and mid-bit sampling.
// Ports:
//   clk, rst_n  system clock / async active-low reset
//   rxd         serial input, asynchronous to clk
//   rx_byte     last assembled byte (valid when rx_stb is high)
//   rx_stb      one-cycle pulse, the edge after a good stop-bit sample
//   rx_par_err  one-cycle pulse on a parity mismatch (parity build only)
// Optional build macro: UART_PARITY_EN adds the PARITY sampling state.
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | waiting for a low level on the synchronised line
// ST_START     | half a bit in, re-checking the start bit
// ST_DATA      | sampling data bit bit_idx each bit period
// ST_PARITY    | sampling the parity bit (parity build)
// ST_STOP      | sampling the stop bit
// ST_WAIT_IDLE | framing error seen, waiting for the line to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
`ifdef UART_PARITY_EN
  output logic       rx_par_err,
`endif
  output logic       rx_stb
);

  localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

  logic [1:0]       sync;
  logic             rx_s;
  uart_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             stb_nxt;
`ifdef UART_PARITY_EN
  logic             par_bad, par_bad_nxt, perr_nxt;
`endif

  assign rx_s    = sync[1];
  assign rx_byte = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= {2{IDLE_LEVEL}};
      state   <= ST_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      rx_stb  <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad    <= 1'b0;
      rx_par_err <= 1'b0;
`endif
    end else begin
      sync    <= {sync[0], rxd};
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
      rx_stb  <= stb_nxt;
`ifdef UART_PARITY_EN
      par_bad    <= par_bad_nxt;
      rx_par_err <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    stb_nxt     = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_nxt   = HALF_BIT;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          // A line already back high at mid start bit was a glitch.
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt   = ST_DATA;
            cnt_nxt     = BIT_RELOAD;
            bit_idx_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          shreg_nxt = {rx_s, shreg[7:1]};
          cnt_nxt   = BIT_RELOAD;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (cnt == '0) begin
          par_bad_nxt = rx_s ^ (^shreg);
          state_nxt   = ST_STOP;
          cnt_nxt     = BIT_RELOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_nxt = ST_IDLE;
`ifdef UART_PARITY_EN
            perr_nxt  = par_bad;
            stb_nxt   = !par_bad;
`else
            stb_nxt   = 1'b1;
`endif
          end else begin
            state_nxt = ST_WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialiser, 8 data bits LSB first, one stop bit.
// Ports:
//   clk, rst_n      system clock / async active-low reset
//   tx_data, tx_we  byte and single-cycle write strobe (ignored while busy)
//   tx_busy         high from the accepting edge until the edge ending STOP
//   txd             serial line, idle high
// Optional build macro: UART_PARITY_EN inserts an even-parity bit before STOP.
//
// state     | meaning
// ----------+------------------------------------------
// ST_IDLE   | line idle, waiting for tx_we
// ST_START  | driving the start bit (low)
// ST_DATA   | driving data bit bit_idx
// ST_PARITY | driving the even-parity bit (parity build)
// ST_STOP   | driving the stop bit (high)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  output logic       txd
);

  localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

  uart_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             txd_nxt;
`ifdef UART_PARITY_EN
  logic             par, par_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      txd     <= IDLE_LEVEL;
`ifdef UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
      txd     <= txd_nxt;
`ifdef UART_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

  // txd is registered so the line changes on the same edge the state does;
  // the shift register always presents the next bit to send at shreg[0].
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
    txd_nxt     = txd;
`ifdef UART_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      ST_IDLE: begin
        if (tx_we) begin
          state_nxt = ST_START;
          shreg_nxt = tx_data;
          cnt_nxt   = BIT_RELOAD;
          txd_nxt   = 1'b0;
`ifdef UART_PARITY_EN
          par_nxt   = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          state_nxt   = ST_DATA;
          cnt_nxt     = BIT_RELOAD;
          bit_idx_nxt = '0;
          txd_nxt     = shreg[0];
          shreg_nxt   = {1'b0, shreg[7:1]};
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          cnt_nxt = BIT_RELOAD;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
            state_nxt = ST_PARITY;
            txd_nxt   = par;
`else
            state_nxt = ST_STOP;
            txd_nxt   = IDLE_LEVEL;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            txd_nxt     = shreg[0];
            shreg_nxt   = {1'b0, shreg[7:1]};
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (cnt == '0) begin
          state_nxt = ST_STOP;
          cnt_nxt   = BIT_RELOAD;
          txd_nxt   = IDLE_LEVEL;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          txd_nxt   = IDLE_LEVEL;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        txd_nxt   = IDLE_LEVEL;
      end
    endcase
  end

  assign tx_busy = (state != ST_IDLE);

endmodule

// File: rtl/uart_mmio_core.sv
// uart_mmio_core: byte-wide UART behind the DATA/STATUS MMIO window.
// Instantiates uart_tx and uart_rx and owns the one-byte receive holding
// register with its valid / overrun flags.
// Ports:
//   clk, rst_n           system clock / async active-low reset
//   tx_data, tx_we       CPU write of the data register
//   tx_busy              transmitter occupied (STATUS bit1)
//   rx_re                CPU read of the data register (level)
//   rx_data, rx_valid    holding register and unread flag (STATUS bit0)
//   rx_overrun           sticky, a byte overwrote an unread one
//   rx_parity_err        sticky parity error (UART_PARITY_EN builds only)
//   txd, rxd             serial lines
// Optional build macro: UART_PARITY_EN.
module uart_mmio_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_busy,
  input  logic       rx_re,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
`ifdef UART_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       txd,
  input  logic       rxd
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);

  logic [7:0] rx_byte;
  logic       rx_stb;
`ifdef UART_PARITY_EN
  logic       rx_par_err;
`endif

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_we   (tx_we),
    .tx_busy (tx_busy),
    .txd     (txd)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_byte    (rx_byte),
`ifdef UART_PARITY_EN
    .rx_par_err (rx_par_err),
`endif
    .rx_stb     (rx_stb)
  );

  // A commit always wins over a same-edge read; the read then only serves
  // to acknowledge the byte being replaced, so overrun is not raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (rx_stb) begin
      rx_data  <= rx_byte;
      rx_valid <= 1'b1;
      if (rx_re)         rx_overrun <= 1'b0;
      else if (rx_valid) rx_overrun <= 1'b1;
    end else if (rx_re) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rx_parity_err <= 1'b0;
    else if (rx_par_err) rx_parity_err <= 1'b1;
    else if (rx_re)      rx_parity_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_mmio_core.sv
module tb_uart_mmio_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_we = 1'b0;
  logic       rx_re = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       tx_busy, rx_valid, rx_overrun, txd, rxd;
  logic [7:0] rx_data;

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_q[$];
  logic       tx_q[$];

  assign rxd = loopback ? txd : rxd_drv;

  uart_mmio_core #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_we      (tx_we),
    .tx_busy    (tx_busy),
    .rx_re      (rx_re),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .txd        (txd),
    .rxd        (rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on rxd from a negedge; good frames go to the scoreboard.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd_drv = frame[k];
      repeat (10) @(negedge clk);
    end
    rxd_drv = 1'b1;
    if (stop_bit) rx_q.push_back(b);
    repeat (3) @(negedge clk);
  endtask

  // Drain the scoreboard: the last byte must be in rx_data, overrun iff more
  // than one byte arrived without a read.
  task automatic expect_rx(input string tag);
    int         n;
    logic [7:0] exp;
    for (int i = 0; i < 20 && rx_valid !== 1'b1; i++) @(negedge clk);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    n   = rx_q.size();
    exp = 8'hxx;
    while (rx_q.size() > 0) exp = rx_q.pop_front();
    chk({tag, "_data"}, 32'(rx_data), 32'(exp));
    chk({tag, "_ovr"}, 32'(rx_overrun), (n > 1) ? 32'd1 : 32'd0);
  endtask

  task automatic read_pulse();
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
  endtask

  logic [7:0] lb [3];
  logic       exp_bit;

  initial begin
    lb = '{8'h00, 8'hFF, 8'hC3};
    exp_bit = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_state", 32'({txd, tx_busy, rx_valid, rx_overrun, rx_data}), 32'h800);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle", 32'({txd, tx_busy, rx_valid}), 32'b100);
    end

    // 2: TX 0xA5 with a dropped write at cycle 40
    tx_data = 8'hA5;
    tx_we   = 1'b1;
    tx_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) tx_q.push_back(tx_data[k]);
    tx_q.push_back(1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 10 == 0) exp_bit = tx_q.pop_front();
      chk("tx_bit", 32'(txd), 32'(exp_bit));
      chk("tx_busy", 32'(tx_busy), 32'd1);
      if (i == 0)  begin tx_we = 1'b0; tx_data = 8'h00; end
      if (i == 39) begin tx_we = 1'b1; tx_data = 8'h3C; end
      if (i == 40) begin tx_we = 1'b0; tx_data = 8'h00; end
    end
    @(negedge clk);
    chk("tx_done", 32'({txd, tx_busy}), 32'b10);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("tx_drop", 32'({txd, tx_busy}), 32'b10);
    end

    // 3: RX 0x5A then read
    send_rx(8'h5A, 1'b1);
    expect_rx("rx5a");
    read_pulse();
    chk("rx_re_clr", 32'(rx_valid), 32'd0);

    // 4: overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    expect_rx("ovr");
    read_pulse();
    chk("ovr_clr", 32'({rx_valid, rx_overrun}), 32'd0);

    // 5: glitch, framing error, recovery
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch", 32'(rx_valid), 32'd0);
    send_rx(8'h7E, 1'b0);
    repeat (20) @(negedge clk);
    chk("ferr", 32'(rx_valid), 32'd0);
    send_rx(8'h81, 1'b1);
    expect_rx("after_ferr");
    read_pulse();
    chk("ferr_clr", 32'(rx_valid), 32'd0);

    // 6: loopback, back-to-back frames; read lands on the 0xFF commit edge
    loopback = 1'b1;
    repeat (5) @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      tx_data = lb[f];
      tx_we   = 1'b1;
      rx_q.push_back(lb[f]);
      for (int i = 1; i <= 100; i++) begin
        @(negedge clk);
        if (i == 1) tx_we = 1'b0;
        if (f == 2 && i == 50) rx_re = 1'b1;
        if (f == 2 && i == 51) rx_re = 1'b0;
        if (f == 1 && i == 100) rx_re = 1'b1;
      end
      @(negedge clk);
      rx_re = 1'b0;
      chk("lb_busy", 32'(tx_busy), 32'd0);
      chk("lb_valid", 32'(rx_valid), 32'd1);
      chk("lb_data", 32'(rx_data), 32'(rx_q.pop_front()));
      chk("lb_ovr", 32'(rx_overrun), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
